// File: rtl/axis_step_scheduler.sv
// axis_step_scheduler: two-axis step/dir pulse generator, CPU or jog source.
// Optional soft position limits: define AXIS_STEP_SCHEDULER_LIMIT_EN.

module axis_step_axis #(
    parameter int DIV_W     = 24,
    parameter int PULSE_W   = 100,
    parameter int DIR_SETUP = 200,
    parameter int POS_W     = 16
`ifdef AXIS_STEP_SCHEDULER_LIMIT_EN
    ,
    parameter int POS_MIN   = -1000,
    parameter int POS_MAX   = 1000
`endif
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic             dir,
    input  logic [DIV_W-1:0] period,
    output logic             pin_step,
    output logic             pin_dir,
    output logic [POS_W-1:0] pos,
    output logic             active
`ifdef AXIS_STEP_SCHEDULER_LIMIT_EN
    ,
    output logic             limit
`endif
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_DIR_SETUP,
        S_STEP_HIGH,
        S_STEP_LOW
    } state_t;

    localparam logic [DIV_W-1:0] MIN_P   = DIV_W'(2 * PULSE_W);
    localparam logic [DIV_W-1:0] HI_LAST = DIV_W'(PULSE_W - 1);
    localparam logic [DIV_W-1:0] SU_LAST = DIV_W'(DIR_SETUP - 1);
    localparam logic [DIV_W-1:0] LOW_OFF = DIV_W'(PULSE_W + 1);

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] low_last;
    logic [DIV_W-1:0] pe;
    logic [POS_W-1:0] pos_nxt;
    logic             same_dir;
    logic             want_step;
    logic             step_ok;

    assign pe       = (period < MIN_P) ? MIN_P : period;
    assign same_dir = (dir == pin_dir);
    assign pos_nxt  = pin_dir ? pos - POS_W'(1) : pos + POS_W'(1);
    assign active   = (state != S_IDLE);

`ifdef AXIS_STEP_SCHEDULER_LIMIT_EN
    logic signed [31:0] pos_s;
    assign pos_s   = {{(32 - POS_W){pos[POS_W-1]}}, pos};
    assign step_ok = pin_dir ? (pos_s - 32'sd1 >= POS_MIN)
                             : (pos_s + 32'sd1 <= POS_MAX);
`else
    assign step_ok = 1'b1;
`endif

    // Flag the cycles on which the FSM would start a new step pulse
    always_comb begin
        want_step = 1'b0;
        unique case (state)
            S_IDLE:      want_step = run && same_dir;
            S_DIR_SETUP: want_step = run && same_dir && cnt == SU_LAST;
            S_STEP_LOW:  want_step = run && same_dir && cnt == low_last;
            default:     want_step = 1'b0;
        endcase
    end

    // Step/direction FSM with registered pins and position
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            low_last <= '0;
            pin_step <= 1'b0;
            pin_dir  <= 1'b0;
            pos      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (run && !same_dir) begin
                        state   <= S_DIR_SETUP;
                        pin_dir <= dir;
                    end else if (want_step && step_ok) begin
                        state    <= S_STEP_HIGH;
                        pin_step <= 1'b1;
                        pos      <= pos_nxt;
                    end
                end
                S_DIR_SETUP: begin
                    if (!run) begin
                        state <= S_IDLE;
                    end else if (!same_dir) begin
                        pin_dir <= dir;
                        cnt     <= '0;
                    end else if (cnt == SU_LAST) begin
                        cnt <= '0;
                        if (step_ok) begin
                            state    <= S_STEP_HIGH;
                            pin_step <= 1'b1;
                            pos      <= pos_nxt;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STEP_HIGH: begin
                    if (cnt == HI_LAST) begin
                        state    <= S_STEP_LOW;
                        pin_step <= 1'b0;
                        cnt      <= '0;
                        low_last <= pe - LOW_OFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STEP_LOW: begin
                    if (!run && cnt >= HI_LAST) begin
                        state <= S_IDLE;
                    end else if (cnt == low_last) begin
                        cnt <= '0;
                        if (!same_dir) begin
                            state   <= S_DIR_SETUP;
                            pin_dir <= dir;
                        end else if (step_ok) begin
                            state    <= S_STEP_HIGH;
                            pin_step <= 1'b1;
                            pos      <= pos_nxt;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef AXIS_STEP_SCHEDULER_LIMIT_EN
    // Hold the limit flag while a step in the requested direction is refused
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            limit <= 1'b0;
        end else if (state == S_IDLE || want_step) begin
            limit <= want_step && !step_ok;
        end
    end
`endif
endmodule

module axis_step_scheduler #(
    parameter int DIV_W         = 24,
    parameter int PULSE_W       = 100,
    parameter int DIR_SETUP     = 200,
    parameter int MANUAL_PERIOD = 500000,
    parameter int POS_W         = 16
`ifdef AXIS_STEP_SCHEDULER_LIMIT_EN
    ,
    parameter int POS_MIN       = -1000,
    parameter int POS_MAX       = 1000
`endif
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             manual_en,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic [31:0]      x_speed,
    input  logic [31:0]      y_speed,
    input  logic [31:0]      x_dir,
    input  logic [31:0]      y_dir,
    output logic             pin_x_step,
    output logic             pin_x_dir,
    output logic             pin_y_step,
    output logic             pin_y_dir,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic             busy,
    output logic             source
`ifdef AXIS_STEP_SCHEDULER_LIMIT_EN
    ,
    output logic             x_limit,
    output logic             y_limit
`endif
);
    localparam logic [DIV_W-1:0] MAN_P = DIV_W'(MANUAL_PERIOD);

    logic [4:0]       sync1;
    logic [4:0]       sync2;
    logic             man_s;
    logic             left_s;
    logic             right_s;
    logic             up_s;
    logic             down_s;
    logic             x_run_c;
    logic             y_run_c;
    logic             x_dir_c;
    logic             y_dir_c;
    logic [DIV_W-1:0] x_per_c;
    logic [DIV_W-1:0] y_per_c;
    logic             x_run_q;
    logic             y_run_q;
    logic             x_dir_q;
    logic             y_dir_q;
    logic [DIV_W-1:0] x_per_q;
    logic [DIV_W-1:0] y_per_q;
    logic             x_act;
    logic             y_act;
    logic             unused_bits;

    assign {man_s, left_s, right_s, up_s, down_s} = sync2;
    assign unused_bits = ^{x_speed[31:DIV_W], y_speed[31:DIV_W],
                           x_dir[31:1], y_dir[31:1]};

    // Two-flop synchronizers for the mode switch and jog buttons
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {manual_en, btn_left, btn_right, btn_up, btn_down};
            sync2 <= sync1;
        end
    end

    // Pick each axis request from the active source
    always_comb begin
        x_run_c = 1'b0;
        y_run_c = 1'b0;
        x_dir_c = 1'b0;
        y_dir_c = 1'b0;
        x_per_c = '0;
        y_per_c = '0;
        if (source) begin
            x_run_c = left_s ^ right_s;
            x_dir_c = left_s;
            x_per_c = MAN_P;
            y_run_c = up_s ^ down_s;
            y_dir_c = up_s;
            y_per_c = MAN_P;
        end else begin
            x_per_c = x_speed[DIV_W-1:0];
            x_run_c = |x_per_c;
            x_dir_c = x_dir[0];
            y_per_c = y_speed[DIV_W-1:0];
            y_run_c = |y_per_c;
            y_dir_c = y_dir[0];
        end
    end

    // Register requests so the axis FSMs see a clean, one-cycle-late view
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_run_q <= 1'b0;
            y_run_q <= 1'b0;
            x_dir_q <= 1'b0;
            y_dir_q <= 1'b0;
            x_per_q <= '0;
            y_per_q <= '0;
        end else begin
            x_run_q <= x_run_c;
            y_run_q <= y_run_c;
            x_dir_q <= x_dir_c;
            y_dir_q <= y_dir_c;
            x_per_q <= x_per_c;
            y_per_q <= y_per_c;
        end
    end

    // Switch source only with both axes idle so no move is cut short
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            source <= 1'b0;
            busy   <= 1'b0;
        end else begin
            if (!x_act && !y_act) begin
                source <= man_s;
            end
            busy <= x_act | y_act;
        end
    end

    axis_step_axis #(
        .DIV_W     (DIV_W),
        .PULSE_W   (PULSE_W),
        .DIR_SETUP (DIR_SETUP),
        .POS_W     (POS_W)
`ifdef AXIS_STEP_SCHEDULER_LIMIT_EN
        ,
        .POS_MIN   (POS_MIN),
        .POS_MAX   (POS_MAX)
`endif
    ) u_x (
        .clock    (clock),
        .reset_n  (reset_n),
        .run      (x_run_q),
        .dir      (x_dir_q),
        .period   (x_per_q),
        .pin_step (pin_x_step),
        .pin_dir  (pin_x_dir),
        .pos      (x_pos),
        .active   (x_act)
`ifdef AXIS_STEP_SCHEDULER_LIMIT_EN
        ,
        .limit    (x_limit)
`endif
    );

    axis_step_axis #(
        .DIV_W     (DIV_W),
        .PULSE_W   (PULSE_W),
        .DIR_SETUP (DIR_SETUP),
        .POS_W     (POS_W)
`ifdef AXIS_STEP_SCHEDULER_LIMIT_EN
        ,
        .POS_MIN   (POS_MIN),
        .POS_MAX   (POS_MAX)
`endif
    ) u_y (
        .clock    (clock),
        .reset_n  (reset_n),
        .run      (y_run_q),
        .dir      (y_dir_q),
        .period   (y_per_q),
        .pin_step (pin_y_step),
        .pin_dir  (pin_y_dir),
        .pos      (y_pos),
        .active   (y_act)
`ifdef AXIS_STEP_SCHEDULER_LIMIT_EN
        ,
        .limit    (y_limit)
`endif
    );
endmodule

// File: tb/tb_axis_step_scheduler.sv
// tb_axis_step_scheduler: directed checks of step timing, direction,
// source switching, jog buttons, wrap and asynchronous reset.

module tb_axis_step_scheduler;
    localparam int PW = 4;
    localparam int DS = 8;
    localparam int MP = 20;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        manual_en = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic [31:0] x_speed = '0;
    logic [31:0] y_speed = '0;
    logic [31:0] x_dir = '0;
    logic [31:0] y_dir = '0;
    logic        pin_x_step, pin_x_dir, pin_y_step, pin_y_dir;
    logic [15:0] x_pos, y_pos;
    logic        busy, source;
    logic        s_x_step, s_x_dir, s_y_step, s_y_dir;
    logic [3:0]  sx_pos, sy_pos;
    logic        s_busy, s_source;
`ifdef AXIS_STEP_SCHEDULER_LIMIT_EN
    logic        x_limit, y_limit, s_x_limit, s_y_limit;
`endif

    int checks = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    axis_step_scheduler #(
        .PULSE_W(PW), .DIR_SETUP(DS), .MANUAL_PERIOD(MP), .POS_W(16)
    ) dut (
        .clock(clock), .reset_n(reset_n), .manual_en(manual_en),
        .btn_left(btn_left), .btn_right(btn_right),
        .btn_up(btn_up), .btn_down(btn_down),
        .x_speed(x_speed), .y_speed(y_speed),
        .x_dir(x_dir), .y_dir(y_dir),
        .pin_x_step(pin_x_step), .pin_x_dir(pin_x_dir),
        .pin_y_step(pin_y_step), .pin_y_dir(pin_y_dir),
        .x_pos(x_pos), .y_pos(y_pos), .busy(busy), .source(source)
`ifdef AXIS_STEP_SCHEDULER_LIMIT_EN
        , .x_limit(x_limit), .y_limit(y_limit)
`endif
    );

    axis_step_scheduler #(
        .PULSE_W(PW), .DIR_SETUP(DS), .MANUAL_PERIOD(MP), .POS_W(4)
    ) dut_small (
        .clock(clock), .reset_n(reset_n), .manual_en(manual_en),
        .btn_left(btn_left), .btn_right(btn_right),
        .btn_up(btn_up), .btn_down(btn_down),
        .x_speed(x_speed), .y_speed(y_speed),
        .x_dir(x_dir), .y_dir(y_dir),
        .pin_x_step(s_x_step), .pin_x_dir(s_x_dir),
        .pin_y_step(s_y_step), .pin_y_dir(s_y_dir),
        .x_pos(sx_pos), .y_pos(sy_pos), .busy(s_busy), .source(s_source)
`ifdef AXIS_STEP_SCHEDULER_LIMIT_EN
        , .x_limit(s_x_limit), .y_limit(s_y_limit)
`endif
    );

    task automatic wait_rise(input bit ax, input int budget, output int t);
        logic prev, cur;
        prev = ax ? pin_y_step : pin_x_step;
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            cur = ax ? pin_y_step : pin_x_step;
            if (cur && !prev) begin
                t = cyc;
                return;
            end
            prev = cur;
        end
    endtask

    task automatic high_width(input bit ax, output int w);
        w = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if ((ax ? pin_y_step : pin_x_step) !== 1'b1) return;
            w++;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (busy === 1'b0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({pin_x_step, pin_x_dir, pin_y_step, pin_y_dir, busy, source} !== 6'b0) begin
            fails++;
            $display("FAIL reset_pins: got %b required 000000",
                     {pin_x_step, pin_x_dir, pin_y_step, pin_y_dir, busy, source});
        end
        checks++;
        if (x_pos !== 16'd0 || y_pos !== 16'd0) begin
            fails++;
            $display("FAIL reset_pos: got x=%h y=%h required 0", x_pos, y_pos);
        end
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (pin_x_step !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: got step=%b busy=%b required 0", pin_x_step, busy);
        end
    endtask

    task automatic test_cpu_run;
        int t0, t, w;
        bit ok;
        x_speed = 32'd10;
        x_dir = 32'd0;
        @(negedge clock);
        checks++;
        if (pin_x_step !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: got %b required 0", pin_x_step);
        end
        @(negedge clock);
        checks++;
        if (pin_x_step !== 1'b1) begin
            fails++;
            $display("FAIL latency_rise: got %b required 1", pin_x_step);
        end
        t0 = cyc;
        checks++;
        if (x_pos !== 16'd1) begin
            fails++;
            $display("FAIL run_pos1: got %0d required 1", x_pos);
        end
        high_width(1'b0, w);
        checks++;
        if (w !== PW) begin
            fails++;
            $display("FAIL run_width1: got %0d required %0d", w, PW);
        end
        for (int k = 2; k <= 5; k++) begin
            wait_rise(1'b0, 40, t);
            checks++;
            if (t - t0 !== 10) begin
                fails++;
                $display("FAIL run_spacing%0d: got %0d required 10", k, t - t0);
            end
            checks++;
            if (x_pos !== 16'(k)) begin
                fails++;
                $display("FAIL run_pos%0d: got %0d required %0d", k, x_pos, k);
            end
            t0 = t;
            if (k < 5) begin
                high_width(1'b0, w);
                checks++;
                if (w !== PW) begin
                    fails++;
                    $display("FAIL run_width%0d: got %0d required %0d", k, w, PW);
                end
            end
        end
        x_speed = 32'd0;
        checks++;
        if (pin_x_dir !== 1'b0) begin
            fails++;
            $display("FAIL run_dir: got %b required 0", pin_x_dir);
        end
        wait_idle(40, ok);
        checks++;
        if (!ok || x_pos !== 16'd5) begin
            fails++;
            $display("FAIL run_stop: got idle=%0d pos=%0d required idle=1 pos=5", ok, x_pos);
        end
    endtask

    task automatic test_clamp;
        int t0, t1, t2, w;
        bit ok;
        x_speed = 32'd3;
        wait_rise(1'b0, 20, t0);
        high_width(1'b0, w);
        checks++;
        if (w !== PW) begin
            fails++;
            $display("FAIL clamp_width: got %0d required %0d", w, PW);
        end
        wait_rise(1'b0, 40, t1);
        checks++;
        if (t0 < 0 || t1 - t0 !== 2 * PW) begin
            fails++;
            $display("FAIL clamp_spacing1: got %0d required %0d", t1 - t0, 2 * PW);
        end
        checks++;
        if (x_pos !== 16'd7 || sx_pos !== 4'h7) begin
            fails++;
            $display("FAIL clamp_pos7: got %0d/%h required 7/7", x_pos, sx_pos);
        end
        wait_rise(1'b0, 40, t2);
        x_speed = 32'd0;
        checks++;
        if (t2 - t1 !== 2 * PW) begin
            fails++;
            $display("FAIL clamp_spacing2: got %0d required %0d", t2 - t1, 2 * PW);
        end
        checks++;
        if (x_pos !== 16'd8 || sx_pos !== 4'h8) begin
            fails++;
            $display("FAIL wrap_small: got %0d/%h required 8/8", x_pos, sx_pos);
        end
        wait_idle(40, ok);
    endtask

    task automatic test_dir_change;
        int t0, td, t1, w;
        bit ok;
        x_speed = 32'd10;
        x_dir = 32'd0;
        wait_rise(1'b0, 20, t0);
        checks++;
        if (x_pos !== 16'd9) begin
            fails++;
            $display("FAIL dir_pos9: got %0d required 9", x_pos);
        end
        x_dir = 32'd1;
        td = -1;
        w = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (pin_x_dir === 1'b1) begin
                td = cyc;
                break;
            end
            if (pin_x_step === 1'b1) w++;
        end
        checks++;
        if (w !== PW) begin
            fails++;
            $display("FAIL dir_pulse_done: got %0d required %0d", w, PW);
        end
        checks++;
        if (td < 0 || td - t0 !== 10) begin
            fails++;
            $display("FAIL dir_toggle_time: got %0d required 10", td - t0);
        end
        wait_rise(1'b0, 40, t1);
        x_speed = 32'd0;
        checks++;
        if (t1 < 0 || t1 - td !== DS) begin
            fails++;
            $display("FAIL dir_setup: got %0d required %0d", t1 - td, DS);
        end
        checks++;
        if (x_pos !== 16'd8 || pin_x_dir !== 1'b1) begin
            fails++;
            $display("FAIL dir_decrement: got pos=%0d dir=%b required 8/1", x_pos, pin_x_dir);
        end
        wait_idle(40, ok);
    endtask

    task automatic test_manual;
        int t, td, t0, t1;
        bit ok, held;
        x_speed = 32'd10;
        x_dir = 32'd1;
        wait_rise(1'b0, 20, t);
        checks++;
        if (x_pos !== 16'd7) begin
            fails++;
            $display("FAIL man_xpos: got %0d required 7", x_pos);
        end
        manual_en = 1'b1;
        repeat (4) @(negedge clock);
        checks++;
        if (source !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL man_hold: got src=%b busy=%b required 0/1", source, busy);
        end
        x_speed = 32'd0;
        held = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            if (source !== 1'b0) held = 1'b0;
        end
        checks++;
        if (!ok || !held) begin
            fails++;
            $display("FAIL man_wait_idle: got idle=%0d held=%0d required 1/1", ok, held);
        end
        for (int i = 0; i < 4; i++) begin
            if (source === 1'b1) break;
            @(negedge clock);
        end
        checks++;
        if (source !== 1'b1) begin
            fails++;
            $display("FAIL man_source: got %b required 1", source);
        end
        btn_up = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (pin_y_dir !== 1'b0) begin
            fails++;
            $display("FAIL btn_latency_early: got %b required 0", pin_y_dir);
        end
        @(negedge clock);
        td = cyc;
        checks++;
        if (pin_y_dir !== 1'b1) begin
            fails++;
            $display("FAIL btn_dir: got %b required 1", pin_y_dir);
        end
        wait_rise(1'b1, 40, t0);
        checks++;
        if (t0 < 0 || t0 - td !== DS) begin
            fails++;
            $display("FAIL btn_setup: got %0d required %0d", t0 - td, DS);
        end
        checks++;
        if (y_pos !== 16'hFFFF) begin
            fails++;
            $display("FAIL wrap_neg: got %h required ffff", y_pos);
        end
        wait_rise(1'b1, 60, t1);
        btn_up = 1'b0;
        checks++;
        if (t1 < 0 || t1 - t0 !== MP) begin
            fails++;
            $display("FAIL btn_period: got %0d required %0d", t1 - t0, MP);
        end
        checks++;
        if (y_pos !== 16'hFFFE) begin
            fails++;
            $display("FAIL btn_ypos: got %h required fffe", y_pos);
        end
        wait_idle(60, ok);
    endtask

    task automatic test_both_buttons;
        bit stepped, was_busy;
        btn_left = 1'b1;
        btn_right = 1'b1;
        stepped = 1'b0;
        was_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (pin_x_step !== 1'b0) stepped = 1'b1;
            if (busy !== 1'b0) was_busy = 1'b1;
        end
        checks++;
        if (stepped) begin
            fails++;
            $display("FAIL both_btn_step: got step required none");
        end
        checks++;
        if (was_busy || x_pos !== 16'd7) begin
            fails++;
            $display("FAIL both_btn_busy: got busy=%0d pos=%0d required 0/7", was_busy, x_pos);
        end
        btn_left = 1'b0;
        btn_right = 1'b0;
    endtask

    task automatic test_async_reset;
        int t;
        manual_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (source === 1'b0) break;
        end
        checks++;
        if (source !== 1'b0) begin
            fails++;
            $display("FAIL back_to_cpu: got %b required 0", source);
        end
        x_speed = 32'd10;
        x_dir = 32'd0;
        wait_rise(1'b0, 40, t);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (t < 0 || pin_x_step !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_step: got rise=%0d step=%b required step 0", t, pin_x_step);
        end
        checks++;
        if (x_pos !== 16'd0 || pin_x_dir !== 1'b0 || source !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_state: got pos=%0d dir=%b src=%b required 0", x_pos, pin_x_dir, source);
        end
        x_speed = 32'd0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

`ifdef AXIS_STEP_SCHEDULER_LIMIT_EN
    task automatic test_limit;
        bit ok, stepped;
        x_speed = 32'd3;
        x_dir = 32'd0;
        ok = 1'b0;
        for (int i = 0; i < 9000; i++) begin
            @(negedge clock);
            if (x_pos === 16'd1000) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (12) @(negedge clock);
        stepped = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (pin_x_step !== 1'b0) stepped = 1'b1;
        end
        checks++;
        if (!ok || stepped || x_pos !== 16'd1000) begin
            fails++;
            $display("FAIL limit_block: got reach=%0d step=%0d pos=%0d required 1/0/1000", ok, stepped, x_pos);
        end
        checks++;
        if (x_limit !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL limit_flag: got lim=%b busy=%b required 1/0", x_limit, busy);
        end
        x_speed = 32'd0;
        repeat (3) @(negedge clock);
        checks++;
        if (x_limit !== 1'b0) begin
            fails++;
            $display("FAIL limit_clear: got %b required 0", x_limit);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_run();
        test_clamp();
        test_dir_change();
        test_manual();
        test_both_buttons();
        test_async_reset();
`ifdef AXIS_STEP_SCHEDULER_LIMIT_EN
        test_limit();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/axis_step_scheduler.md
# axis_step_scheduler

Two-axis step-pulse scheduler between the register-file motion outputs (`xSpeed`, `xDirection`, `ySpeed`, `yDirection`) and the X/Y stepper driver pins. It shares the driver between processor-commanded motion and manual push-button jogging. For each axis it generates step/direction pulse trains with a programmable period, enforced pulse width and direction setup time. It also keeps a signed position count per axis.

## Interface
Parameters:
- `DIV_W`, 24 — width of the period field taken from the speed registers.
- `PULSE_W`, 100 — step high time in cycles; also the minimum low time.
- `DIR_SETUP`, 200 — cycles the direction pin is held stable before the first step after a direction change.
- `MANUAL_PERIOD`, 500000 — step period in cycles used while jogging.
- `POS_W`, 16 — position counter width, two's complement.

Ports:
- `clock` in 1 — system clock.
- `reset_n` in 1 — asynchronous, active-low reset.
- `manual_en` in 1 — asynchronous; 1 selects buttons, 0 selects CPU.
- `btn_left`, `btn_right`, `btn_up`, `btn_down` in 1 each — asynchronous jog buttons.
- `x_speed`, `y_speed` in 32 — CPU period request; bits `[DIV_W-1:0]`; 0 means stop.
- `x_dir`, `y_dir` in 32 — CPU direction; bit 0: 1 = left/up (negative), 0 = right/down (positive).
- `pin_x_step`, `pin_x_dir`, `pin_y_step`, `pin_y_dir` out 1 — driver pins.
- `x_pos`, `y_pos` out `POS_W` — signed step counts.
- `busy` out 1 — either axis is not IDLE.
- `source` out 1 — active source: 0 = CPU, 1 = manual.

## Operation
- Inputs `manual_en` and all four buttons pass through 2-flop synchronizers. CPU inputs are used directly; they are synchronous to `clock`.
- Source arbitration:
  - `source` adopts the synchronized `manual_en` only on a cycle where both axes are IDLE.
  - A running move is never truncated by a source change.
- Per-axis request:
  - CPU source: run = period P ≠ 0, where P = `speed[DIV_W-1:0]`; direction = `dir[0]`.
  - Manual source: run = exactly one button of the axis pair pressed, with P = `MANUAL_PERIOD`.
  - Both buttons of a pair pressed means no request on that axis.
- Effective period Pe = max(P, 2·`PULSE_W`).
- Per-axis FSM:
  - IDLE → DIR_SETUP when run and the requested direction ≠ `pin_dir`. `pin_dir` updates on entry.
  - IDLE → STEP_HIGH when run and the direction matches.
  - DIR_SETUP → STEP_HIGH after `DIR_SETUP` cycles. If run drops during DIR_SETUP, return to IDLE.
  - STEP_HIGH → STEP_LOW after `PULSE_W` cycles. Pe is latched on entry to STEP_LOW.
  - STEP_LOW → STEP_HIGH after Pe−`PULSE_W` cycles, if still run with the same direction.
  - STEP_LOW → DIR_SETUP at the same point if run with the other direction.
  - STEP_LOW → IDLE after at least `PULSE_W` low cycles once run drops. An early exit is allowed as soon as `PULSE_W` low cycles are met.
- A period change mid-pulse takes effect at the next STEP_LOW entry.
- Position: on each STEP_HIGH entry, the position counts −1 if `pin_dir`=1 and +1 otherwise. It wraps modulo 2^`POS_W`.

## Timing
- Reset: every output is 0; all FSMs IDLE; positions 0.
- Pins, positions, `busy` and `source` are registered.
- CPU request sampled at edge k in IDLE with matching direction: `pin_step` rises after edge k+1, and the position updates on the same edge.
- Button press: 2 extra cycles of synchronizer latency.
- Step high time is exactly `PULSE_W` cycles. Rising-edge spacing is exactly Pe while the request is steady.
- First step after a direction change rises `DIR_SETUP` cycles after `pin_dir` toggles.
- Simultaneous X and Y requests are fully independent; there is no arbitration between axes.
- Reset asserted mid-pulse forces `pin_step` low immediately (asynchronously).

## Configuration
- `AXIS_STEP_SCHEDULER_LIMIT_EN` defined:
  - Adds parameters `POS_MIN` (−1000) and `POS_MAX` (1000).
  - A step that would move a position outside [`POS_MIN`, `POS_MAX`] is suppressed: the FSM returns to IDLE instead of entering STEP_HIGH.
  - Adds output ports `x_limit` and `y_limit`. Each is 1 while its axis is blocked by a request and 0 otherwise.
- Undefined: no limit ports or parameters exist, and positions wrap freely.

## Test plan
Bench parameters: `PULSE_W`=4, `DIR_SETUP`=8, `MANUAL_PERIOD`=20.

- Reset, then `x_speed`=10 and `x_dir`=0 for 5 periods → rising edges 10 cycles apart, each high 4 cycles, `x_pos`=5, `pin_x_dir`=0.
- `x_speed`=3 → period clamped to 8.
- `x_speed`=10 with `x_dir` toggled to 1 mid-STEP_HIGH → current pulse completes, `pin_x_dir`=1 at the next period boundary, next rise 8 cycles later, `x_pos` then decrements.
- `manual_en` raised while X is running, CPU speed then set to 0 → `source` stays 0 until X reaches IDLE, then `source`=1. Then `btn_up` held → `pin_y_dir`=1, rises every 20 cycles, `y_pos` negative.
- `btn_left` and `btn_right` both held → no X steps and `busy`=0.
- Wrap: start from `x_pos`=0x7FFF with `x_dir`=0, issue 1 step → `x_pos`=0x8000. With `AXIS_STEP_SCHEDULER_LIMIT_EN`, stepping from 1000 positive → no pulse and `x_limit`=1.
